mux8_dig: RTL and testbench

//  Registered 8-to-1 selector: routes one of eight data inputs d0..d7 to

---
 rtl/mux8_dig.sv | 59 +++++
 tb/tb_mux8_dig.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux8_dig.sv
// Registered 8-to-1 selector: y captures d[{s2,s1,s0}] on each enabled rising edge.
// Synchronous active-high reset loads RST_VAL; en=0 holds the current y.
module mux8_dig #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [WIDTH-1:0] y
);

    logic [2:0]       sel_s;
    logic [WIDTH-1:0] y_next_s;
    logic [WIDTH-1:0] y_r;

    assign sel_s = {s2, s1, s0};

    // Select the data input addressed by {s2,s1,s0}; s2 is the MSB.
    always_comb begin
        y_next_s = d0;
        case (sel_s)
            3'd0:    y_next_s = d0;
            3'd1:    y_next_s = d1;
            3'd2:    y_next_s = d2;
            3'd3:    y_next_s = d3;
            3'd4:    y_next_s = d4;
            3'd5:    y_next_s = d5;
            3'd6:    y_next_s = d6;
            3'd7:    y_next_s = d7;
            default: y_next_s = RST_VAL;
        endcase
    end

    // Output register: reset has priority over enable; y holds when en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r <= RST_VAL;
        end else if (en) begin
            y_r <= y_next_s;
        end else begin
            y_r <= y_r;
        end
    end

    assign y = y_r;

endmodule

// File: tb/tb_mux8_dig.sv
// Self-checking bench for mux8_dig: a 1-bit and an 8-bit instance share control,
// a bench-side reference model pushes expected y values to queues, popped after each edge.
module tb_mux8_dig;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] dbit = 8'h00;
    logic [7:0] dbyte [8];
    logic       y1;
    logic [7:0] y8;

    logic       m1 = 1'b0;
    logic [7:0] m8 = 8'h00;
    logic       q1 [$];
    logic [7:0] q8 [$];
    logic       e1;
    logic [7:0] e8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux8_dig #(.WIDTH(1), .RST_VAL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
        .d0(dbit[0]), .d1(dbit[1]), .d2(dbit[2]), .d3(dbit[3]),
        .d4(dbit[4]), .d5(dbit[5]), .d6(dbit[6]), .d7(dbit[7]),
        .y(y1)
    );

    mux8_dig #(.WIDTH(8), .RST_VAL(8'h00)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
        .d0(dbyte[0]), .d1(dbyte[1]), .d2(dbyte[2]), .d3(dbyte[3]),
        .d4(dbyte[4]), .d5(dbyte[5]), .d6(dbyte[6]), .d7(dbyte[7]),
        .y(y8)
    );

    // Reference model: compute expected y for the coming edge, queue it, take the edge.
    task automatic step();
        if (rst) begin
            m1 = 1'b0;
            m8 = 8'h00;
        end else if (en) begin
            m1 = dbit[sel];
            m8 = dbyte[sel];
        end
        q1.push_back(m1);
        q8.push_back(m8);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bytes_random();
        for (int i = 0; i < 8; i++) dbyte[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sel = 3'd5; dbit = 8'hFF;
        for (int i = 0; i < 8; i++) dbyte[i] = 8'hFF;
        step();
        e1 = q1.pop_front(); e8 = q8.pop_front();
        checks++;
        if (y1 !== e1 || y1 !== 1'b0) begin
            errors++;
            $display("FAIL reset y1 got=%b exp=%b", y1, e1);
        end
        checks++;
        if (y8 !== e8 || y8 !== 8'h00) begin
            errors++;
            $display("FAIL reset y8 got=%h exp=%h", y8, e8);
        end
        rst = 1'b0;
    endtask

    task automatic test_walking_one();
        en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            dbit = 8'h01 << s;
            fill_bytes_random();
            step();
            e1 = q1.pop_front(); e8 = q8.pop_front();
            checks++;
            if (y1 !== e1 || y1 !== 1'b1) begin
                errors++;
                $display("FAIL walk1 sel=%0d y1 got=%b exp=%b", s, y1, e1);
            end
            checks++;
            if (y8 !== e8) begin
                errors++;
                $display("FAIL walk1 sel=%0d y8 got=%h exp=%h", s, y8, e8);
            end
        end
    endtask

    task automatic test_walking_zero();
        en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            dbit = ~(8'h01 << s);
            step();
            e1 = q1.pop_front(); e8 = q8.pop_front();
            checks++;
            if (y1 !== e1 || y1 !== 1'b0) begin
                errors++;
                $display("FAIL walk0 sel=%0d y1 got=%b exp=%b", s, y1, e1);
            end
        end
    endtask

    task automatic test_hold();
        en = 1'b1; sel = 3'd7; dbit = 8'h80; dbyte[7] = 8'hA5;
        step();
        e1 = q1.pop_front(); e8 = q8.pop_front();
        checks++;
        if (y1 !== 1'b1 || y8 !== 8'hA5) begin
            errors++;
            $display("FAIL hold_load got=%b/%h exp=1/a5", y1, y8);
        end
        en = 1'b0; dbit = 8'h00; dbyte[7] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            sel = 3'(k);
            step();
            e1 = q1.pop_front(); e8 = q8.pop_front();
            checks++;
            if (y1 !== e1 || y1 !== 1'b1 || y8 !== e8 || y8 !== 8'hA5) begin
                errors++;
                $display("FAIL hold edge=%0d got=%b/%h exp=1/a5", k, y1, y8);
            end
        end
    endtask

    task automatic test_reset_priority();
        en = 1'b1; sel = 3'd3; dbit = 8'h08; dbyte[3] = 8'h3C;
        step();
        e1 = q1.pop_front(); e8 = q8.pop_front();
        checks++;
        if (y1 !== 1'b1 || y8 !== 8'h3C) begin
            errors++;
            $display("FAIL rstprio_load got=%b/%h exp=1/3c", y1, y8);
        end
        rst = 1'b1;
        step();
        e1 = q1.pop_front(); e8 = q8.pop_front();
        checks++;
        if (y1 !== e1 || y1 !== 1'b0 || y8 !== 8'h00) begin
            errors++;
            $display("FAIL rstprio_assert got=%b/%h exp=0/00", y1, y8);
        end
        rst = 1'b0;
        step();
        e1 = q1.pop_front(); e8 = q8.pop_front();
        checks++;
        if (y1 !== e1 || y1 !== 1'b1 || y8 !== 8'h3C) begin
            errors++;
            $display("FAIL rstprio_release got=%b/%h exp=1/3c", y1, y8);
        end
    endtask

    task automatic test_width8_sweep();
        en = 1'b1;
        for (int i = 0; i < 8; i++) dbyte[i] = 8'h10 + 8'(i);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            e1 = q1.pop_front(); e8 = q8.pop_front();
            checks++;
            if (y8 !== e8 || y8 !== 8'h10 + 8'(s)) begin
                errors++;
                $display("FAIL w8_sweep sel=%0d got=%h exp=%h", s, y8, 8'h10 + 8'(s));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 15) == 0);
            sel  = 3'($urandom_range(0, 7));
            dbit = 8'($urandom);
            fill_bytes_random();
            step();
            e1 = q1.pop_front(); e8 = q8.pop_front();
            checks++;
            if (y1 !== e1 || y8 !== e8) begin
                errors++;
                $display("FAIL b2b n=%0d got=%b/%h exp=%b/%h", n, y1, y8, e1, e8);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dbyte[i] = 8'h00;
        #2;
        test_reset();
        test_walking_one();
        test_walking_zero();
        test_hold();
        test_reset_priority();
        test_width8_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
